// File: rtl/fadd_ctrl.sv
// Issue/collect sequencer in front of the multi-cycle FP32 adder: one operation in flight.
// Optional sticky exception flags are built when FADD_CTRL_FFLAGS_EN is defined.
module fadd_ctrl #(
    parameter int unsigned LAT = 3,
    parameter int unsigned CW  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rslt,
    output logic [4:0]  out_flag,
    output logic        fa_req,
    output logic [31:0] fa_x,
    output logic [31:0] fa_y,
    input  logic [31:0] fa_rslt,
`ifdef FADD_CTRL_FFLAGS_EN
    output logic [4:0]  fflags,
    input  logic        fflags_clr,
`endif
    input  logic [4:0]  fa_flag
);

    localparam int unsigned DW = 32;
    localparam int unsigned FW = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   xr_q, xr_d;
    logic [DW-1:0]   yr_q, yr_d;
    logic [DW-1:0]   rslt_q, rslt_d;
    logic [FW-1:0]   flag_q, flag_d;
    logic            fa_req_q, fa_req_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
`ifdef FADD_CTRL_FFLAGS_EN
    logic [FW-1:0]   fflags_q, fflags_d;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        xr_d     = xr_q;
        yr_d     = yr_q;
        rslt_d   = rslt_q;
        flag_d   = flag_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    xr_d    = in_x;
                    yr_d    = in_y;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CW'(LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    rslt_d  = fa_rslt;
                    flag_d  = fa_flag;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake/strobe outputs are registered copies of the next state
        fa_req_d    = (state_d == ISSUE);
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

`ifdef FADD_CTRL_FFLAGS_EN
    // Clear first, then accumulate flags of a result taken in the same cycle
    always_comb begin
        fflags_d = fflags_q;
        if (fflags_clr) begin
            fflags_d = '0;
        end
        if (out_valid_q && out_ready) begin
            fflags_d = fflags_d | flag_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            xr_q        <= '0;
            yr_q        <= '0;
            rslt_q      <= '0;
            flag_q      <= '0;
            fa_req_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            xr_q        <= xr_d;
            yr_q        <= yr_d;
            rslt_q      <= rslt_d;
            flag_q      <= flag_d;
            fa_req_q    <= fa_req_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef FADD_CTRL_FFLAGS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign fflags = fflags_q;
`endif

    // The adder re-reads its operands late, so they come straight from the held registers
    assign fa_x      = xr_q;
    assign fa_y      = yr_q;
    assign fa_req    = fa_req_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_rslt  = rslt_q;
    assign out_flag  = flag_q;

endmodule
